gate_response_checker: RTL and testbench
========================================

Name: gate_response_checker

Overview:
Self-checking response end for the 2-input gate under test (newnand and its siblings in the mux/buffer library).
- Drives the four {A,B} input vectors into the gate, waits a settle window, samples the gate output, and compares it against an expected truth table.
- Reports per-vector failures, an error count and a pass flag.
- Sits beside the gate as an on-chip BIST, replacing the manual waveform check of the stimulus bench.

Parameters:
SETTLE_CYCLES, 4, cycles each vector is held before sampling; must be >= 3 (elaboration check).
EXP_TT, 4'b0111, expected gate output indexed by {A,B}; default is NAND.
RUNS, 1, number of full 4-vector passes per start; must be >= 1.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  in  1  single clock.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  level-sampled request to begin a check; honoured only in IDLE.
dut_a  out  1  registered A input to the gate.
dut_b  out  1  registered B input to the gate.
dut_out  in  1  gate output; asynchronous to the checker, synchronised internally.
busy  out  1  high from start acceptance through the last SAMPLE.
done  out  1  one-cycle pulse when results are final.
pass  out  1  1 if the last completed run had zero errors; updated only at done.
err_count  out  ERR_W  saturating mismatch count for the current/last run.
fail_mask  out  4  bit {A,B} set if that vector mismatched at least once.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, state=IDLE. Reset mid-run aborts immediately; no partial results survive.
- Vector order: {A,B} = 00, 10, 01, 11. Index is {A,B}, so fail_mask bit 2 is A=1,B=0.
- dut_out passes through a 2-flop synchroniser before comparison. SETTLE_CYCLES >= 3 guarantees the sampled value reflects the driven vector.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
  - IDLE: on start=1, load vector 0 onto dut_a/dut_b, clear err_count and fail_mask, clear the run counter, load cnt=SETTLE_CYCLES-1, set busy=1, go to SETTLE.
  - SETTLE: if cnt==0 go to SAMPLE, else decrement cnt. Lasts exactly SETTLE_CYCLES cycles.
  - SAMPLE (1 cycle): compare the synchronised output with EXP_TT[{dut_a,dut_b}].
    - On mismatch: err_count += 1, saturating at all-ones; set fail_mask[{dut_a,dut_b}].
    - If vector 3 and last run: go to DONE, busy=0.
    - Otherwise: advance the vector (wrap 3->0 and increment the run counter), reload cnt, go to SETTLE.
  - DONE (1 cycle): done=1, pass=(err_count==0, including any mismatch from the final SAMPLE), dut_a/dut_b return to 0, go to IDLE.
- Latency: start sampled at edge k gives busy=1 from k+1 and done=1 in cycle k+1+RUNS*4*(SETTLE_CYCLES+1). Default: k+21.
- start while busy or in DONE is ignored.
- start held high starts a new run in the cycle after DONE.
- pass holds its value across a new run until the next done.

Decomposition:
- Package gate_check_pkg: state enum (IDLE/SETTLE/SAMPLE/DONE), vector-order constant array {00,10,01,11}, NAND_TT=4'b0111 and AND_TT=4'b1000 constants.
- One sub-module: sync_2ff (clk, rst_n, d, q), reset to 0, used for dut_out.

Test Plan:
1. Ideal NAND model, defaults, start pulse -> dut_a/dut_b step 00,10,01,11, each held 5 cycles; done at k+21; pass=1, err_count=0, fail_mask=4'b0000.
2. AND model instead of NAND -> all four vectors mismatch; err_count=4, fail_mask=4'b1111, pass=0.
3. Output stuck-at-1 -> only vector 11 fails; err_count=1, fail_mask=4'b1000, pass=0.
4. RUNS=100, ERR_W=8, output stuck-at-0 -> 300 mismatches, err_count saturates at 255, fail_mask=4'b0111, done at k+1+2000.
5. Extra start pulses during busy -> ignored, same timing as case 1. Then rst_n=0 mid-SETTLE -> all outputs 0 immediately; a fresh start after release passes per case 1.
6. start held high across two runs, first with a faulty model and second with an ideal one -> second run begins the cycle after done; err_count/fail_mask clear at acceptance; pass stays 0 until the second done, then becomes 1.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared constants for the 2-input gate response checker.
//   - FSM state encoding (IDLE/SETTLE/SAMPLE/DONE) as plain localparams so legacy
//     code that compares raw state bits keeps working.
//   - Vector drive order and the common expected truth tables, indexed by {A,B}.
package gate_check_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StSettle = 2'd1;
  localparam state_t StSample = 2'd2;
  localparam state_t StDone   = 2'd3;

  // Entry i is the {A,B} pair driven as the i-th vector of a pass: 00, 10, 01, 11.
  localparam logic [3:0][1:0] VEC_ORDER = {2'b11, 2'b01, 2'b10, 2'b00};

  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] AND_TT  = 4'b1000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, output resets to 0
//   d     - asynchronous input
//   q     - synchronised output (two clk cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/gate_response_checker.sv
// On-chip response checker for a 2-input gate. Drives the four {A,B} vectors in the
// order 00, 10, 01, 11, holds each for SETTLE_CYCLES, samples the synchronised gate
// output and compares it with EXP_TT[{A,B}]. Repeats RUNS passes per start.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - level request, accepted only in IDLE
//   dut_a, dut_b - registered gate inputs
//   dut_out      - gate output (asynchronous, synchronised here)
//   busy         - high from acceptance through the final SAMPLE
//   done         - one-cycle pulse when results are final
//   pass         - last completed run had zero mismatches (updated with done)
//   err_count    - saturating mismatch count of current/last run
//   fail_mask    - bit {A,B} set if that vector ever mismatched
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  EXP_TT        = NAND_TT,
  parameter int unsigned RUNS          = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_mask
);

  // Two sync flops plus one cycle of gate settling need at least three hold cycles.
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 3");
  end
  if (RUNS < 1) begin : g_bad_runs
    $error("RUNS must be >= 1");
  end

  localparam int unsigned CntW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned RunW = (RUNS > 1) ? $clog2(RUNS) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);
  localparam logic [RunW-1:0] RunLast = RunW'(RUNS - 1);

  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       vec_q, vec_d;
  logic [RunW-1:0]  run_q, run_d;
  logic             a_q, a_d, b_q, b_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fail_q, fail_d;
  logic             pass_q, pass_d;
  logic             out_sync;
  logic             mismatch;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (out_sync)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    run_d    = run_q;
    a_d      = a_q;
    b_d      = b_q;
    err_d    = err_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    mismatch = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          vec_d      = 2'd0;
          {a_d, b_d} = VEC_ORDER[0];
          err_d      = '0;
          fail_d     = '0;
          run_d      = '0;
          cnt_d      = CntLoad;
          state_d    = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSample: begin
        mismatch = (out_sync != EXP_TT[{a_q, b_q}]);
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end
          fail_d[{a_q, b_q}] = 1'b1;
        end
        if (vec_q == 2'd3 && run_q == RunLast) begin
          // pass uses err_d so a mismatch on the very last sample is included.
          pass_d  = (err_d == '0);
          a_d     = 1'b0;
          b_d     = 1'b0;
          state_d = StDone;
        end else begin
          vec_d = vec_q + 2'd1;
          if (vec_q == 2'd3) begin
            run_d = run_q + 1'b1;
          end
          {a_d, b_d} = VEC_ORDER[vec_d];
          cnt_d      = CntLoad;
          state_d    = StSettle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      vec_q   <= '0;
      run_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      run_q   <= run_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_a     = a_q;
  assign dut_b     = b_q;
  assign busy      = (state_q == StSettle) || (state_q == StSample);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = fail_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: a behavioural gate model (NAND, AND, stuck-at-1,
// stuck-at-0) feeds two checkers, one with defaults and one with RUNS=100.
// Expected results are pushed to a scoreboard at launch and popped at done.
module tb_gate_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1;
  logic [1:0] mode;

  logic       a0, b0, o0, busy0, done0, pass0;
  logic [7:0] err0;
  logic [3:0] mask0;
  logic       a1, b1, o1, busy1, done1, pass1;
  logic [7:0] err1;
  logic [3:0] mask1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int         done_cyc;
    int         err;
    logic [3:0] mask;
    logic       pass;
  } exp_t;
  exp_t sb[$];

  // Gate model: 0 NAND, 1 AND, 2 stuck-at-1, 3 stuck-at-0.
  function automatic logic gate_fn(input logic [1:0] m, input logic a, input logic b);
    case (m)
      2'd0:    return ~(a & b);
      2'd1:    return a & b;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign o0 = gate_fn(mode, a0, b0);
  assign o1 = gate_fn(mode, a1, b1);

  gate_response_checker u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start0),
    .dut_a     (a0),
    .dut_b     (b0),
    .dut_out   (o0),
    .busy      (busy0),
    .done      (done0),
    .pass      (pass0),
    .err_count (err0),
    .fail_mask (mask0)
  );

  gate_response_checker #(
    .SETTLE_CYCLES (4),
    .RUNS          (100),
    .ERR_W         (8)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .dut_a     (a1),
    .dut_b     (b1),
    .dut_out   (o1),
    .busy      (busy1),
    .done      (done1),
    .pass      (pass1),
    .err_count (err1),
    .fail_mask (mask1)
  );

  // Expected results against an ideal NAND, saturating at 255.
  function automatic exp_t make_exp(input int done_cyc, input logic [1:0] m, input int runs);
    exp_t       e;
    int         per;
    logic [1:0] v;
    per    = 0;
    e.mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      v = i[1:0];
      if (gate_fn(m, v[1], v[0]) !== ~(v[1] & v[0])) begin
        per++;
        e.mask[i] = 1'b1;
      end
    end
    e.err      = (per * runs > 255) ? 255 : per * runs;
    e.pass     = (per == 0);
    e.done_cyc = done_cyc;
    return e;
  endfunction

  // Called #1 after an edge with the checker idle. Returns k = cyc after the edge
  // that sampled start; done is then seen after edge k+runs*20 (cycle k+1+runs*20).
  task automatic launch(input bit big, input int runs, output int k);
    if (big) start1 = 1'b1;
    else     start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    k = cyc;
    sb.push_back(make_exp(k + runs * 20, mode, runs));
  endtask

  task automatic await_done(input bit big, input int limit, output int seen);
    seen = -1;
    for (int i = 0; i < limit; i++) begin
      if (big ? done1 : done0) begin
        seen = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    mode   = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({a0, b0, busy0, done0, pass0, err0, mask0, a1, b1, busy1, done1, pass1, err1, mask1}
        !== '0) begin
      n_miss++;
      $display("FAIL reset_values got dut0=%b%b%b%b%b %h %b dut1=%b%b%b%b%b %h %b want all 0",
               a0, b0, busy0, done0, pass0, err0, mask0, a1, b1, busy1, done1, pass1, err1,
               mask1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({busy0, done0, busy1, done1} !== 4'b0000) begin
      n_miss++;
      $display("FAIL reset_release got busy/done=%b%b%b%b want 0000", busy0, done0, busy1,
               done1);
    end
  endtask

  task automatic test_nand_ideal();
    int         k;
    exp_t       e;
    logic [1:0] order [4];
    logic [1:0] want;
    order = '{2'b00, 2'b10, 2'b01, 2'b11};
    mode  = 2'd0;
    launch(1'b0, 1, k);
    for (int i = 0; i < 20; i++) begin
      want = order[i / 5];
      n_vec++;
      if ({busy0, a0, b0} !== {1'b1, want}) begin
        n_miss++;
        $display("FAIL nand_vector step=%0d got busy,a,b=%b%b%b want 1%b", i, busy0, a0, b0,
                 want);
      end
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    n_vec++;
    if (!(done0 === 1'b1 && cyc == e.done_cyc)) begin
      n_miss++;
      $display("FAIL nand_done got done=%b at %0d want done=1 at %0d", done0, cyc, e.done_cyc);
    end
    n_vec++;
    if ({pass0, err0, mask0} !== {e.pass, 8'(e.err), e.mask}) begin
      n_miss++;
      $display("FAIL nand_result got pass=%b err=%0d mask=%b want pass=%b err=%0d mask=%b",
               pass0, err0, mask0, e.pass, e.err, e.mask);
    end
    n_vec++;
    if ({busy0, a0, b0} !== 3'b000) begin
      n_miss++;
      $display("FAIL nand_done_idle got busy,a,b=%b%b%b want 000", busy0, a0, b0);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done0 !== 1'b0) begin
      n_miss++;
      $display("FAIL nand_done_pulse got done=%b want 0", done0);
    end
  endtask

  task automatic test_and_model();
    int   k, seen;
    exp_t e;
    mode = 2'd1;
    launch(1'b0, 1, k);
    await_done(1'b0, 40, seen);
    e = sb.pop_front();
    n_vec++;
    if (seen != e.done_cyc) begin
      n_miss++;
      $display("FAIL and_done_cycle got %0d want %0d", seen, e.done_cyc);
    end
    n_vec++;
    if ({pass0, err0, mask0} !== {e.pass, 8'(e.err), e.mask}) begin
      n_miss++;
      $display("FAIL and_result got pass=%b err=%0d mask=%b want pass=%b err=%0d mask=%b",
               pass0, err0, mask0, e.pass, e.err, e.mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stuck_one();
    int   k, seen;
    exp_t e;
    mode = 2'd2;
    launch(1'b0, 1, k);
    await_done(1'b0, 40, seen);
    e = sb.pop_front();
    n_vec++;
    if (seen != e.done_cyc) begin
      n_miss++;
      $display("FAIL stuck1_done_cycle got %0d want %0d", seen, e.done_cyc);
    end
    n_vec++;
    if ({pass0, err0, mask0} !== {e.pass, 8'(e.err), e.mask}) begin
      n_miss++;
      $display("FAIL stuck1_result got pass=%b err=%0d mask=%b want pass=%b err=%0d mask=%b",
               pass0, err0, mask0, e.pass, e.err, e.mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    int   k, seen;
    exp_t e;
    mode = 2'd3;
    launch(1'b1, 100, k);
    await_done(1'b1, 2100, seen);
    e = sb.pop_front();
    n_vec++;
    if (seen != e.done_cyc) begin
      n_miss++;
      $display("FAIL sat_done_cycle got %0d want %0d", seen, e.done_cyc);
    end
    n_vec++;
    if ({pass1, err1, mask1} !== {e.pass, 8'(e.err), e.mask}) begin
      n_miss++;
      $display("FAIL sat_result got pass=%b err=%0d mask=%b want pass=%b err=%0d mask=%b",
               pass1, err1, mask1, e.pass, e.err, e.mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_and_reset();
    int   k, seen;
    exp_t e;
    mode = 2'd0;
    launch(1'b0, 1, k);
    // Extra start pulses in SETTLE and SAMPLE must not disturb the run.
    for (int i = 0; i < 40 && done0 !== 1'b1; i++) begin
      start0 = (i == 2 || i == 7 || i == 13 || i == 19);
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    seen   = done0 ? cyc : -1;
    e      = sb.pop_front();
    n_vec++;
    if (seen != e.done_cyc) begin
      n_miss++;
      $display("FAIL ignore_done_cycle got %0d want %0d", seen, e.done_cyc);
    end
    n_vec++;
    if ({pass0, err0, mask0} !== {e.pass, 8'(e.err), e.mask}) begin
      n_miss++;
      $display("FAIL ignore_result got pass=%b err=%0d mask=%b want pass=%b err=%0d mask=%b",
               pass0, err0, mask0, e.pass, e.err, e.mask);
    end
    // start raised only during DONE: the IDLE cycle that follows sees it low.
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({busy0, done0} !== 2'b00) begin
      n_miss++;
      $display("FAIL done_start_ignored got busy,done=%b%b want 00", busy0, done0);
    end

    // Faulty run interrupted by reset once an error has been recorded.
    mode = 2'd1;
    launch(1'b0, 1, k);
    repeat (7) @(posedge clk);
    #1;
    n_vec++;
    if ({busy0, a0, b0, err0} !== {3'b110, 8'd1}) begin
      n_miss++;
      $display("FAIL midrun_state got busy,a,b=%b%b%b err=%0d want 110 err=1", busy0, a0, b0,
               err0);
    end
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_vec++;
    if ({a0, b0, busy0, done0, pass0, err0, mask0} !== '0) begin
      n_miss++;
      $display("FAIL midrun_reset got a,b,busy,done,pass=%b%b%b%b%b err=%0d mask=%b want 0",
               a0, b0, busy0, done0, pass0, err0, mask0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mode = 2'd0;
    launch(1'b0, 1, k);
    await_done(1'b0, 40, seen);
    e = sb.pop_front();
    n_vec++;
    if (seen != e.done_cyc) begin
      n_miss++;
      $display("FAIL fresh_done_cycle got %0d want %0d", seen, e.done_cyc);
    end
    n_vec++;
    if ({pass0, err0, mask0} !== {e.pass, 8'(e.err), e.mask}) begin
      n_miss++;
      $display("FAIL fresh_result got pass=%b err=%0d mask=%b want pass=%b err=%0d mask=%b",
               pass0, err0, mask0, e.pass, e.err, e.mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_held_start();
    int   k, seen;
    exp_t e;
    bit   pass_leak;
    mode   = 2'd2;
    start0 = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    sb.push_back(make_exp(k + 20, 2'd2, 1));
    await_done(1'b0, 40, seen);
    e = sb.pop_front();
    n_vec++;
    if ({seen == e.done_cyc, pass0, err0, mask0} !== {1'b1, e.pass, 8'(e.err), e.mask}) begin
      n_miss++;
      $display("FAIL held_first got cyc=%0d pass=%b err=%0d mask=%b want cyc=%0d %b %0d %b",
               seen, pass0, err0, mask0, e.done_cyc, e.pass, e.err, e.mask);
    end
    // Second run accepted in the IDLE cycle after DONE.
    mode = 2'd0;
    sb.push_back(make_exp(seen + 22, 2'd0, 1));
    @(posedge clk); #1;
    n_vec++;
    if ({busy0, done0, pass0} !== 3'b000) begin
      n_miss++;
      $display("FAIL held_idle got busy,done,pass=%b%b%b want 000", busy0, done0, pass0);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({busy0, pass0, err0, mask0} !== {2'b10, 8'd0, 4'd0}) begin
      n_miss++;
      $display("FAIL held_accept got busy=%b pass=%b err=%0d mask=%b want 1 0 0 0000", busy0,
               pass0, err0, mask0);
    end
    start0    = 1'b0;
    pass_leak = 1'b0;
    seen      = -1;
    for (int i = 0; i < 40; i++) begin
      if (done0) begin
        seen = cyc;
        break;
      end
      if (pass0 !== 1'b0) pass_leak = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (pass_leak) begin
      n_miss++;
      $display("FAIL held_pass_hold got pass=1 before second done want 0");
    end
    e = sb.pop_front();
    n_vec++;
    if ({seen == e.done_cyc, pass0, err0, mask0} !== {1'b1, e.pass, 8'(e.err), e.mask}) begin
      n_miss++;
      $display("FAIL held_second got cyc=%0d pass=%b err=%0d mask=%b want cyc=%0d %b %0d %b",
               seen, pass0, err0, mask0, e.done_cyc, e.pass, e.err, e.mask);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got time limit reached want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nand_ideal();
    test_and_model();
    test_stuck_one();
    test_saturate();
    test_ignore_and_reset();
    test_held_start();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
